// File: rtl/riscv_mem_responder.sv
// Word-addressed RAM plus MMIO (console TX, CYCLE, HALT) for the multi-cycle RISC-V core; console present only with RISCV_MEM_CONSOLE_EN.
// Latency: instr and mem_read_data are registered (1 cycle); stores take effect on their own edge.
// Backpressure: none toward the core; console bytes drain via tx_valid/tx_ready, and a push into a full FIFO is dropped and sets ovf.

`ifdef RISCV_MEM_CONSOLE_EN
module riscv_mem_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign head_dat = mem[rptr];
    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
endmodule
`endif

module riscv_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int TX_DEPTH  = 8,
    parameter int TX_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] pc,
    output logic [31:0] instr,
    input  logic [29:0] mem_addr,
    input  logic        mem_write,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int          AW           = $clog2(MEM_WORDS);
    localparam logic [29:0] ADDR_TX_DATA = 30'h3FFF_FFFC;
    localparam logic [29:0] ADDR_TX_STS  = 30'h3FFF_FFFD;
    localparam logic [29:0] ADDR_CYCLE   = 30'h3FFF_FFFE;
    localparam logic [29:0] ADDR_HALT    = 30'h3FFF_FFFF;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    logic [31:0] ram [MEM_WORDS];
    logic [31:0] cycle;
    logic [31:0] status_word;
    logic [31:0] rd_next;
    logic        pc_ram, d_ram;
    logic        wr_tx_data, wr_tx_sts, wr_cycle, wr_halt;

    assign pc_ram     = (pc < 30'(MEM_WORDS));
    assign d_ram      = (mem_addr < 30'(MEM_WORDS));
    assign wr_tx_data = mem_write && (mem_addr == ADDR_TX_DATA);
    assign wr_tx_sts  = mem_write && (mem_addr == ADDR_TX_STS);
    assign wr_cycle   = mem_write && (mem_addr == ADDR_CYCLE);
    assign wr_halt    = mem_write && (mem_addr == ADDR_HALT);

`ifdef RISCV_MEM_CONSOLE_EN
    localparam int GW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

    logic [GW-1:0] gap;
    logic          ovf, fifo_empty, fifo_full, tx_pop, tx_push;
    logic [7:0]    fifo_head;

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push     = wr_tx_data && (!fifo_full || tx_pop);
    assign tx_valid    = !fifo_empty && (gap == '0);
    assign tx_data     = fifo_empty ? 8'h00 : fifo_head;
    assign status_word = {29'b0, ovf, fifo_full, fifo_empty};

    riscv_mem_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tx_push),
        .push_dat (mem_write_data[7:0]),
        .pop      (tx_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= '0;
            ovf <= 1'b0;
        end else begin
            if (tx_pop)          gap <= GW'(TX_DIV - 1);
            else if (gap != '0)  gap <= gap - GW'(1);
            if (wr_tx_data && !tx_push)                ovf <= 1'b1;
            else if (wr_tx_sts && mem_write_data[2])   ovf <= 1'b0;
        end
    end
`else
    logic unused_console;

    assign tx_valid       = 1'b0;
    assign tx_data        = 8'h00;
    assign status_word    = 32'h0000_0001;
    assign unused_console = &{1'b0, tx_ready, wr_tx_data, wr_tx_sts};
`endif

    always_comb begin
        rd_next = 32'h0;
        if (d_ram) begin
            rd_next = ram[mem_addr[AW-1:0]];
        end else begin
            case (mem_addr)
                ADDR_TX_STS: rd_next = status_word;
                ADDR_CYCLE:  rd_next = cycle;
                ADDR_HALT:   rd_next = halt_code;
                default:     rd_next = 32'h0;
            endcase
        end
    end

    // RAM contents survive reset, so the array lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_write && d_ram) ram[mem_addr[AW-1:0]] <= mem_write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr         <= 32'h0;
            mem_read_data <= 32'h0;
            cycle         <= 32'h0;
            halt          <= 1'b0;
            halt_code     <= 32'h0;
        end else begin
            instr         <= pc_ram ? ram[pc[AW-1:0]] : NOP;
            mem_read_data <= rd_next;
            cycle         <= wr_cycle ? mem_write_data : cycle + 32'd1;
            if (wr_halt) begin
                halt      <= 1'b1;
                halt_code <= mem_write_data;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed scenarios plus random traffic against a queue/array reference model.
module tb_riscv_mem_responder;
    localparam int          MEM_WORDS = 1024;
    localparam int          TX_DEPTH  = 8;
    localparam int          TX_DIV    = 4;
    localparam logic [29:0] A_TXD = 30'h3FFF_FFFC;
    localparam logic [29:0] A_STS = 30'h3FFF_FFFD;
    localparam logic [29:0] A_CYC = 30'h3FFF_FFFE;
    localparam logic [29:0] A_HLT = 30'h3FFF_FFFF;
    localparam logic [29:0] A_BAD = 30'h2000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [29:0] pc = '0;
    logic [29:0] mem_addr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_write_data = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] instr, mem_read_data, halt_code;
    logic        tx_valid, halt;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    riscv_mem_responder #(.MEM_WORDS(MEM_WORDS), .TX_DEPTH(TX_DEPTH), .TX_DIV(TX_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instr          (instr),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .halt           (halt),
        .halt_code      (halt_code)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sparse RAM, byte queue, cycles since last transfer.
    logic [31:0] ram_m [int];
    logic [7:0]  q [$];
    bit          ovf_m;
    int          since_m;
    bit          halt_m;
    logic [31:0] code_m;
    logic [31:0] cyc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
`ifdef RISCV_MEM_CONSOLE_EN
        return {29'b0, ovf_m, q.size() == TX_DEPTH, q.size() == 0};
`else
        return 32'h0000_0001;
`endif
    endfunction

    function automatic bit valid_m();
`ifdef RISCV_MEM_CONSOLE_EN
        return (q.size() > 0) && (since_m >= TX_DIV);
`else
        return 1'b0;
`endif
    endfunction

    // Called at posedge+1: drive inputs, check pre-edge console outputs, advance one edge, check registered outputs.
    task automatic step(input logic [29:0] p, input logic we, input logic [29:0] a,
                        input logic [31:0] wd, input logic rdy);
        logic [31:0] e_instr, e_rd;
        bit          k_instr, k_rd, e_valid, xfer;
        pc = p; mem_write = we; mem_addr = a; mem_write_data = wd; tx_ready = rdy;
        e_valid = valid_m();
        chk("tx_valid", 32'(tx_valid), 32'(e_valid));
        if (e_valid) chk("tx_data", 32'(tx_data), 32'(q[0]));
`ifndef RISCV_MEM_CONSOLE_EN
        chk("tx_data_off", 32'(tx_data), 32'h0);
`endif
        xfer    = e_valid && rdy;
        k_instr = 1'b1;
        e_instr = NOP;
        if (p < 30'(MEM_WORDS)) begin
            k_instr = ram_m.exists(int'(p));
            if (k_instr) e_instr = ram_m[int'(p)];
        end
        k_rd = 1'b1;
        e_rd = 32'h0;
        if (a < 30'(MEM_WORDS)) begin
            k_rd = ram_m.exists(int'(a));
            if (k_rd) e_rd = ram_m[int'(a)];
        end else if (a == A_STS) e_rd = status_m();
        else if (a == A_CYC) e_rd = cyc_m;
        else if (a == A_HLT) e_rd = code_m;
        cyc_m = (we && a == A_CYC) ? wd : cyc_m + 32'd1;
        if (we && a < 30'(MEM_WORDS)) ram_m[int'(a)] = wd;
        if (we && a == A_HLT) begin halt_m = 1'b1; code_m = wd; end
`ifdef RISCV_MEM_CONSOLE_EN
        if (xfer) begin
            void'(q.pop_front());
            since_m = 1;
        end else if (since_m < TX_DIV) since_m++;
        if (we && a == A_TXD) begin
            if (q.size() < TX_DEPTH) q.push_back(wd[7:0]);
            else ovf_m = 1'b1;
        end
        if (we && a == A_STS && wd[2]) ovf_m = 1'b0;
`endif
        @(posedge clk); #1;
        if (k_instr) chk("instr", instr, e_instr);
        if (k_rd) chk("rdata", mem_read_data, e_rd);
        chk("halt", 32'(halt), 32'(halt_m));
        chk("halt_code", halt_code, code_m);
    endtask

    // Called at posedge+1: reset falls between edges, outputs must clear before the next edge.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        mem_write = 1'b0;
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_rdata", mem_read_data, 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_halt_code", halt_code, 32'h0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        q.delete();
        ovf_m   = 1'b0;
        since_m = TX_DIV;
        halt_m  = 1'b0;
        code_m  = 32'h0;
        cyc_m   = 32'h0;
    endtask

    function automatic logic [29:0] rand_ram();
        return ($urandom_range(0, 1) == 0) ? 30'($urandom_range(0, 15)) : 30'($urandom_range(1008, 1023));
    endfunction

    initial begin
        logic [29:0] a, p;
        logic [31:0] seen [4];
        int          guard;

        @(posedge clk); #1;
        do_reset();

        // RAM round trip with same-cycle old-value read, then RAM boundaries and unmapped space
        step(30'd0, 1'b1, 30'd5, 32'h1111_1111, 1'b0);
        step(30'd5, 1'b1, 30'd5, 32'hDEAD_BEEF, 1'b0);
        chk("ram_old", mem_read_data, 32'h1111_1111);
        step(30'd5, 1'b0, 30'd5, 32'h0, 1'b0);
        chk("ram_new", mem_read_data, 32'hDEAD_BEEF);
        chk("fetch_new", instr, 32'hDEAD_BEEF);
        step(30'd1024, 1'b1, 30'd1023, 32'hA5A5_0001, 1'b0);
        chk("fetch_nop", instr, NOP);
        step(30'd1023, 1'b1, A_BAD, 32'h1234_5678, 1'b0);
        step(30'd0, 1'b0, A_BAD, 32'h0, 1'b0);
        step(30'd0, 1'b0, A_TXD, 32'h0, 1'b0);

        // CYCLE load and wrap
        step(30'd0, 1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(30'd0, 1'b0, A_CYC, 32'h0, 1'b0);
            seen[i] = mem_read_data;
        end
        chk("cycle_ff", seen[1], 32'hFFFF_FFFF);
        chk("cycle_wrap0", seen[2], 32'h0);
        chk("cycle_wrap1", seen[3], 32'h1);

        // Console pacing: two bytes, ready held high
        step(30'd0, 1'b1, A_TXD, 32'h41, 1'b1);
        step(30'd0, 1'b1, A_TXD, 32'h42, 1'b1);
        for (int i = 0; i < 12; i++) step(30'd0, 1'b0, A_STS, 32'h0, 1'b1);
        chk("sts_after_drain", mem_read_data, 32'h1);

        // Overflow, ovf clear, push accepted alongside a pop
        for (int i = 0; i < 9; i++) step(30'd0, 1'b1, A_TXD, 32'h60 + i, 1'b0);
        step(30'd0, 1'b0, A_STS, 32'h0, 1'b0);
`ifdef RISCV_MEM_CONSOLE_EN
        chk("sts_ovf_full", mem_read_data, 32'h6);
`endif
        step(30'd0, 1'b1, A_STS, 32'h4, 1'b0);
        step(30'd0, 1'b0, A_STS, 32'h0, 1'b0);
`ifdef RISCV_MEM_CONSOLE_EN
        chk("sts_ovf_clr", mem_read_data, 32'h2);
`endif
        step(30'd0, 1'b1, A_TXD, 32'h77, 1'b1);
        step(30'd0, 1'b0, A_STS, 32'h0, 1'b0);
        guard = 0;
        while ((q.size() > 0) && (guard < 200)) begin
            step(30'd0, 1'b0, A_STS, 32'h0, 1'b1);
            guard++;
        end
        chk("drain_bound", 32'(q.size()), 32'h0);

        // Backpressure: byte held stable while the sink stalls
        step(30'd0, 1'b1, A_TXD, 32'h5A, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(30'd0, 1'b0, A_STS, 32'h0, 1'b0);
`ifdef RISCV_MEM_CONSOLE_EN
            chk("bp_data", 32'(tx_data), 32'h5A);
`endif
        end
        for (int i = 0; i < 3; i++) step(30'd0, 1'b0, A_STS, 32'h0, 1'b1);

        // HALT: sticky flag, code follows later writes
        step(30'd0, 1'b1, A_HLT, 32'h0000_002A, 1'b0);
        chk("halt_set", 32'(halt), 32'h1);
        chk("halt_code_2a", halt_code, 32'h2A);
        step(30'd0, 1'b0, A_HLT, 32'h0, 1'b0);
        step(30'd0, 1'b1, A_HLT, 32'h0000_0055, 1'b0);
        step(30'd0, 1'b0, A_HLT, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 30'(MEM_WORDS + $urandom_range(0, 3)) : rand_ram();
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = rand_ram();
                4:          a = A_TXD;
                5:          a = A_STS;
                6:          a = A_CYC;
                7:          a = A_HLT;
                8:          a = A_BAD;
                default:    a = 30'(MEM_WORDS);
            endcase
            step(p, ($urandom_range(0, 2) == 0), a, $urandom, 1'($urandom_range(0, 1)));
        end

        // Async reset while a byte is being offered
        step(30'd0, 1'b1, A_TXD, 32'hC3, 1'b0);
        guard = 0;
        while (!valid_m() && (guard < 50)) begin
            step(30'd0, 1'b0, A_STS, 32'h0, 1'b0);
            guard++;
        end
`ifdef RISCV_MEM_CONSOLE_EN
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
`endif
        tx_ready = 1'b1;
        do_reset();
        step(30'd5, 1'b0, A_STS, 32'h0, 1'b1);
        chk("post_rst_sts", mem_read_data, 32'h1);
        step(30'd0, 1'b1, A_TXD, 32'h99, 1'b0);
        step(30'd0, 1'b0, A_CYC, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
